line_clear_ctrl: RTL

//  Sequences the board row store during the main FSM CLEAR state.
//  On start it scans rows bottom (0) to top (ROWS-1) and removes every full row.
//  It compacts the surviving rows downward, zero-fills the vacated top rows, then pulses done.
//  It also reports the number of lines cleared for the score logic.

---
 rtl/tetris_pkg.sv | 28 ++
 rtl/row_full_detect.sv | 14 +
 rtl/line_clear_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// Shared board geometry, row-address sentinel and line-clear state encoding.
// main_FSM's which_row decode uses the same constants.
package tetris_pkg;

  localparam int ROWS  = 11;
  localparam int COLS  = 10;
  localparam int ROW_W = 4;
  localparam int CNT_W = 4;

  localparam logic [ROW_W-1:0] NO_ROW   = 4'b1011;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(ROWS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN_RD  = 3'd1,
    SCAN_CHK = 3'd2,
    FILL     = 3'd3,
    DONE     = 3'd4
  } lc_state_t;

  // The count can never exceed the number of rows on the board.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= MAX_CNT) return v;
    return v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/row_full_detect.sv
// A row is full when every cell is occupied.
// The landing/row-check logic reuses this block.
module row_full_detect
  import tetris_pkg::*;
#(
  parameter int W = COLS
) (
  input  logic [W-1:0] row,
  output logic         full
);

  assign full = &row;

endmodule

// File: rtl/line_clear_ctrl.sv
// Removes full rows from the board row store during CLEAR.
// Survivors are compacted downward, vacated top rows are zero-filled, and the cleared count is reported.
//
// state    | meaning
// IDLE     | waiting for start
// SCAN_RD  | read row rd_ptr
// SCAN_CHK | read data valid; drop full row or move survivor to wr_ptr
// FILL     | zero rows wr_ptr..ROWS-1
// DONE     | pulse done, publish lines_cleared
module line_clear_ctrl
  import tetris_pkg::*;
(
  input  logic             clka,
  input  logic             restart,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] lines_cleared,
  output logic             row_rd_en,
  output logic [ROW_W-1:0] row_rd_addr,
  input  logic [COLS-1:0]  row_rd_data,
  output logic             row_wr_en,
  output logic [ROW_W-1:0] row_wr_addr,
  output logic [COLS-1:0]  row_wr_data
);

  lc_state_t        state_q, state_d;
  logic [ROW_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ROW_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lines_q, lines_d;
  logic             row_full;

  row_full_detect #(.W(COLS)) u_full (
    .row  (row_rd_data),
    .full (row_full)
  );

  always_ff @(posedge clka or posedge restart) begin
    if (restart) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      lines_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      lines_q  <= lines_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    lines_d     = lines_q;
    busy        = 1'b0;
    done        = 1'b0;
    row_rd_en   = 1'b0;
    row_rd_addr = '0;
    row_wr_en   = 1'b0;
    row_wr_addr = '0;
    row_wr_data = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SCAN_RD;
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          cnt_d    = '0;
        end
      end

      SCAN_RD: begin
        busy        = 1'b1;
        row_rd_en   = 1'b1;
        row_rd_addr = rd_ptr_q;
        state_d     = SCAN_CHK;
      end

      SCAN_CHK: begin
        busy = 1'b1;
        if (row_full) begin
          cnt_d = sat_inc(cnt_q);
        end else begin
          // A survivor already in place needs no rewrite.
          if (wr_ptr_q != rd_ptr_q) begin
            row_wr_en   = 1'b1;
            row_wr_addr = wr_ptr_q;
            row_wr_data = row_rd_data;
          end
          if (wr_ptr_q != LAST_ROW) wr_ptr_d = wr_ptr_q + ROW_W'(1);
        end
        if (rd_ptr_q == LAST_ROW) begin
          if (cnt_d == '0) begin
            state_d = DONE;
            lines_d = cnt_d;
          end else begin
            state_d = FILL;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + ROW_W'(1);
          state_d  = SCAN_RD;
        end
      end

      FILL: begin
        busy        = 1'b1;
        row_wr_en   = 1'b1;
        row_wr_addr = wr_ptr_q;
        if (wr_ptr_q == LAST_ROW) begin
          state_d = DONE;
          lines_d = cnt_q;
        end else begin
          wr_ptr_d = wr_ptr_q + ROW_W'(1);
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign lines_cleared = lines_q;

endmodule
